mux_tree_pipe: RTL and testbench



---
 rtl/mux_tree_pipe.sv | 154 +++++++++++++++
 tb/tb_mux_tree_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe.sv
// Pipelined WIDTH-bit NUM_IN:1 mux tree with valid/ready flow control and flush.
// Optional MUX_SEL_RANGE_CHECK_EN adds out_err for selects >= NUM_IN.
module mux_tree_pipe #(
    parameter int WIDTH         = 64,
    parameter int NUM_IN        = 8,
    parameter int LVL_PER_STAGE = 1,
    localparam int LEVELS       = $clog2(NUM_IN),
    localparam int SEL_W        = LEVELS,
    localparam int LAT          = (LEVELS + LVL_PER_STAGE - 1) / LVL_PER_STAGE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_SEL_RANGE_CHECK_EN
    ,
    output logic                    out_err
`endif
);

    localparam int N2 = 1 << LEVELS;

    logic [LAT-1:0] w_vld;
    logic [LAT:0]   w_rdy;

    // A stage accepts when empty or when its occupant moves on this cycle.
    always_comb begin
        w_rdy      = '0;
        w_rdy[LAT] = out_ready;
        for (int s = LAT - 1; s >= 0; s--) begin
            w_rdy[s] = !w_vld[s] || w_rdy[s+1];
        end
    end

`ifdef MUX_SEL_RANGE_CHECK_EN
    localparam logic [SEL_W:0] NUM_L = (SEL_W + 1)'(NUM_IN);
    logic w_oor;
    assign w_oor = {1'b0, in_sel} >= NUM_L;
`endif

    for (genvar s = 0; s < LAT; s++) begin : g_st
        localparam int LO = s * LVL_PER_STAGE;
        localparam int HI = (LO + LVL_PER_STAGE > LEVELS) ? LEVELS
                                                          : LO + LVL_PER_STAGE;
        localparam int NI = N2 >> LO;
        localparam int NO = N2 >> HI;
        localparam int SW = LEVELS - LO;
        localparam int RW = LEVELS - HI;

        logic [NI*WIDTH-1:0] w_din;
        logic [SW-1:0]       w_sin;
        logic                w_vin;
        logic [WIDTH-1:0]    w_t [NI];
        logic [NO*WIDTH-1:0] w_dout;
        logic [NO*WIDTH-1:0] r_data;
        logic                r_valid;

        if (s == 0) begin : g_in
            // Leaves beyond NUM_IN are zero, so out-of-range selects give 0.
            always_comb begin
                w_din                   = '0;
                w_din[NUM_IN*WIDTH-1:0] = in_data;
            end
            assign w_sin = in_sel;
            assign w_vin = in_valid;
        end else begin : g_in
            assign w_din = g_st[s-1].r_data;
            assign w_sin = g_st[s-1].g_sel.r_sel;
            assign w_vin = g_st[s-1].r_valid;
        end

        always_comb begin
            for (int i = 0; i < NI; i++) begin
                w_t[i] = w_din[i*WIDTH +: WIDTH];
            end
            for (int l = 0; l < HI - LO; l++) begin
                for (int i = 0; i < (NI >> (l + 1)); i++) begin
                    w_t[i] = w_sin[l] ? w_t[2*i+1] : w_t[2*i];
                end
            end
            w_dout = '0;
            for (int i = 0; i < NO; i++) begin
                w_dout[i*WIDTH +: WIDTH] = w_t[i];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (flush) begin
                r_valid <= 1'b0;
            end else if (w_rdy[s]) begin
                r_valid <= w_vin;
                if (w_vin) begin
                    r_data <= w_dout;
                end
            end
        end

        assign w_vld[s] = r_valid;

        if (RW > 0) begin : g_sel
            logic [RW-1:0] r_sel;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sel <= '0;
                end else if (!flush && w_rdy[s] && w_vin) begin
                    r_sel <= w_sin[SW-1:HI-LO];
                end
            end
        end

`ifdef MUX_SEL_RANGE_CHECK_EN
        logic w_ein;
        logic r_err;
        if (s == 0) begin : g_ein
            assign w_ein = w_oor;
        end else begin : g_ein
            assign w_ein = g_st[s-1].r_err;
        end
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                r_err <= 1'b0;
            end else if (w_rdy[s]) begin
                r_err <= w_vin && w_ein;
            end
        end
`endif
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_vld[LAT-1];
    assign out_data  = g_st[LAT-1].r_data;

`ifdef MUX_SEL_RANGE_CHECK_EN
    assign out_err = g_st[LAT-1].r_err;
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(in_valid && in_ready && w_oor))
            else $error("mux_tree_pipe: in_sel out of range");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: behavioural slot model plus
// directed literal checks; a second instance covers NUM_IN=5, LVL_PER_STAGE=2.
module tb_mux_tree_pipe;

    localparam int W   = 64;
    localparam int N   = 8;
    localparam int LAT = 3;
    localparam logic [63:0] PAT = 64'hA5A5_0000_0000_0000;

    logic           clk = 1'b0;
    logic           reset;
    logic           flush;
    logic [N*W-1:0] in_data;
    logic [2:0]     in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;

    logic [39:0]    d2_data;
    logic [2:0]     d2_sel;
    logic           d2_valid;
    logic           d2_ready;
    logic [7:0]     d2_out;
    logic           d2_ovalid;
    logic           d2_oready;
    logic           d2_flush;
`ifdef MUX_SEL_RANGE_CHECK_EN
    logic           out_err;
    logic           d2_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;
    logic [63:0] outq [$];
    logic [2:0] bp_list [5] = '{3'd7, 3'd0, 3'd3, 3'd3, 3'd5};

    logic        mv [LAT];
    logic [63:0] md [LAT];

    always #5 clk = ~clk;

    mux_tree_pipe dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_SEL_RANGE_CHECK_EN
        , .out_err(out_err)
`endif
    );

    mux_tree_pipe #(.WIDTH(8), .NUM_IN(5), .LVL_PER_STAGE(2)) dut2 (
        .clk(clk), .reset(reset), .flush(d2_flush),
        .in_data(d2_data), .in_sel(d2_sel),
        .in_valid(d2_valid), .in_ready(d2_ready),
        .out_data(d2_out), .out_valid(d2_ovalid),
        .out_ready(d2_oready)
`ifdef MUX_SEL_RANGE_CHECK_EN
        , .out_err(d2_err)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] s);
        int   n;
        logic acc;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_sel   = s;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: sel %0d never accepted", s);
        end
    endtask

    task automatic set_pattern();
        for (int k = 0; k < N; k++) begin
            in_data[k*W +: W] = PAT | 64'(k);
        end
    endtask

    function automatic int occ();
        int c;
        c = 0;
        for (int s = 0; s < LAT; s++) begin
            if (mv[s]) c++;
        end
        return c;
    endfunction

    function automatic logic mdl_ready();
        return (occ() < LAT) || out_ready;
    endfunction

    // Model: LAT ordered slots; items advance one slot per cycle into any
    // hole ahead of them, the head leaves when the consumer takes it.
    initial begin
        for (int s = 0; s < LAT; s++) begin
            mv[s] = 1'b0;
            md[s] = '0;
        end
    end

    always @(posedge clk) begin
        logic fin;
        logic [63:0] word;
        fin  = in_valid && mdl_ready();
        word = (int'(in_sel) < N) ? in_data[in_sel*W +: W] : 64'd0;
        if (reset || flush) begin
            for (int s = 0; s < LAT; s++) mv[s] = 1'b0;
        end else begin
            if (mv[LAT-1] && out_ready) mv[LAT-1] = 1'b0;
            for (int s = LAT - 1; s >= 1; s--) begin
                if (!mv[s] && mv[s-1]) begin
                    mv[s]   = 1'b1;
                    md[s]   = md[s-1];
                    mv[s-1] = 1'b0;
                end
            end
            if (fin) begin
                mv[0] = 1'b1;
                md[0] = word;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out_valid", out_valid, mv[LAT-1]);
            chk("m_in_ready", in_ready, mdl_ready());
            if (mv[LAT-1]) chk("m_out_data", out_data, md[LAT-1]);
        end
        if (!reset && out_valid && out_ready) outq.push_back(out_data);
    end

    initial begin
        logic [7:0] bubp;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        out_ready = 1'b1;
        set_pattern();
        for (int k = 0; k < 5; k++) d2_data[k*8 +: 8] = 8'h10 + 8'(k);
        d2_sel    = '0;
        d2_valid  = 1'b0;
        d2_oready = 1'b1;
        d2_flush  = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_d2_valid", d2_ovalid, 0);
        tick();

        // back-to-back, every channel
        for (int k = 0; k < 11; k++) begin
            in_valid = (k < 8);
            in_sel   = 3'(k);
            @(negedge clk);
            if (k >= 3) begin
                chk("exh_valid", out_valid, 1);
                chk("exh_data", out_data, PAT | 64'(k - 3));
            end
            if (k < 8) chk("exh_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();

        // backpressure
        out_ready = 1'b0;
        outq.delete();
        send(3'd7);
        send(3'd0);
        send(3'd3);
        in_valid = 1'b1;
        in_sel   = 3'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_frozen", out_data, PAT | 64'd7);
            tick();
        end
        out_ready = 1'b1;
        send(3'd3);
        send(3'd5);
        repeat (6) tick();
        chk("bp_count", 64'(outq.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < outq.size()) chk("bp_order", outq[i], PAT | 64'(bp_list[i]));
        end

        // bubbles
        bubp = 8'b0000_0101;
        for (int k = 0; k < 8; k++) begin
            in_valid = bubp[k];
            in_sel   = 3'(k);
            @(negedge clk);
            if (k >= 3) chk("bub_valid", out_valid, bubp[k-3]);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        send(3'd2);
        tick();
        tick();
        @(negedge clk);
        chk("bub_collapse_valid", out_valid, 1);
        chk("bub_collapse_data", out_data, PAT | 64'd2);
        chk("bub_collapse_ready", in_ready, 1);
        tick();
        out_ready = 1'b1;
        repeat (2) tick();

        // flush with a request offered in the same cycle
        send(3'd1);
        send(3'd2);
        send(3'd4);
        in_valid = 1'b1;
        in_sel   = 3'd6;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("fl_valid", out_valid, 0);
            tick();
        end
        send(3'd5);
        tick();
        tick();
        @(negedge clk);
        chk("fl_after_valid", out_valid, 1);
        chk("fl_after_data", out_data, PAT | 64'd5);
        tick();

        // non-power-of-2 with two levels per stage
        d2_valid = 1'b1;
        d2_sel   = 3'd4;
        tick();
        d2_sel   = 3'd6;
        tick();
        d2_valid = 1'b0;
        @(negedge clk);
        chk("np2_valid4", d2_ovalid, 1);
        chk("np2_sel4", d2_out, 8'h14);
        tick();
        @(negedge clk);
        chk("np2_valid6", d2_ovalid, 1);
        chk("np2_sel6", d2_out, 8'h00);
`ifdef MUX_SEL_RANGE_CHECK_EN
        chk("np2_err6", d2_err, 1);
`endif
        tick();
        @(negedge clk);
        chk("np2_drain", d2_ovalid, 0);
        tick();

        // reset with the pipe full and stalled
        out_ready = 1'b0;
        send(3'd1);
        send(3'd2);
        send(3'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rmid_valid", out_valid, 0);
        chk("rmid_data", out_data, 0);
        chk("rmid_ready", in_ready, 1);
        tick();
        out_ready = 1'b1;
        repeat (4) tick();

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 3'($urandom);
            for (int k = 0; k < N; k++) in_data[k*W +: W] = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
